// File: rtl/ras.sv
// -----------------------------------------------------------------------------
// ras -- return address stack for the fetch-stage branch predictor.
//
// A circular stack of predicted return targets. Calls push a return address
// and returns pop it. The top index and valid count are exported so fetch can
// checkpoint them, and they can be restored after a mispredict. Restore only
// rewinds the pointer and count; entry contents are left as they are.
//
// Ports:
//   CLK                  in   clock, all state changes on the rising edge
//   nRST                 in   synchronous active-low reset
//   ras_push_valid_in    in   call seen in fetch: push ras_push_target_in
//   ras_push_target_in   in   return address to push (PC[31:1])
//   ras_pop_valid_in     in   return seen in fetch: pop the top entry
//   ras_restore_valid_in in   mispredict: reload index/count from checkpoint
//   ras_restore_index_in in   checkpointed top index
//   ras_restore_count_in in   checkpointed count (0..RAS_ENTRIES)
//   ras_ret_target_out   out  entry at the top index (combinational read)
//   ras_empty_out        out  count is zero
//   ras_index_out        out  current top index
//   ras_count_out        out  current valid entry count
// -----------------------------------------------------------------------------
module ras #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_TARGET_WIDTH = 31
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        ras_push_valid_in,
    input  logic [RAS_TARGET_WIDTH-1:0] ras_push_target_in,
    input  logic                        ras_pop_valid_in,
    output logic [RAS_TARGET_WIDTH-1:0] ras_ret_target_out,
    output logic                        ras_empty_out,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index_out,
    output logic [RAS_INDEX_WIDTH:0]    ras_count_out,
    input  logic                        ras_restore_valid_in,
    input  logic [RAS_INDEX_WIDTH-1:0]  ras_restore_index_in,
    input  logic [RAS_INDEX_WIDTH:0]    ras_restore_count_in
);

    localparam int CW = RAS_INDEX_WIDTH + 1;
    localparam logic [RAS_INDEX_WIDTH-1:0] LAST_IDX  = RAS_INDEX_WIDTH'(RAS_ENTRIES - 1);
    localparam logic [CW-1:0]              FULL_CNT  = CW'(RAS_ENTRIES);

    logic [RAS_TARGET_WIDTH-1:0] entries_r [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  index_r;
    logic [CW-1:0]               count_r;

    logic [RAS_INDEX_WIDTH-1:0]  index_inc_s;
    logic [RAS_INDEX_WIDTH-1:0]  index_dec_s;
    logic [RAS_INDEX_WIDTH-1:0]  index_nxt_s;
    logic [CW-1:0]               count_nxt_s;
    logic                        wr_en_s;
    logic [RAS_INDEX_WIDTH-1:0]  wr_addr_s;
    logic                        not_empty_s;

    // Neighbour indices with explicit wrap so non-power-of-two depths also work.
    always_comb begin
        if (index_r == LAST_IDX) begin
            index_inc_s = {RAS_INDEX_WIDTH{1'b0}};
        end else begin
            index_inc_s = index_r + RAS_INDEX_WIDTH'(1);
        end
        if (index_r == {RAS_INDEX_WIDTH{1'b0}}) begin
            index_dec_s = LAST_IDX;
        end else begin
            index_dec_s = index_r - RAS_INDEX_WIDTH'(1);
        end
    end

    assign not_empty_s = (count_r != {CW{1'b0}});

    // Next-state selection in priority order: restore, push+pop, push, pop.
    always_comb begin
        index_nxt_s = index_r;
        count_nxt_s = count_r;
        wr_en_s     = 1'b0;
        wr_addr_s   = index_r;
        if (ras_restore_valid_in) begin
            index_nxt_s = ras_restore_index_in;
            count_nxt_s = ras_restore_count_in;
        end else if (ras_push_valid_in && ras_pop_valid_in && not_empty_s) begin
            // Return immediately followed by a call: replace the top in place.
            wr_en_s   = 1'b1;
            wr_addr_s = index_r;
        end else if (ras_push_valid_in) begin
            // When full, the advance lands on the oldest entry and overwrites it.
            index_nxt_s = index_inc_s;
            wr_en_s     = 1'b1;
            wr_addr_s   = index_inc_s;
            if (count_r == FULL_CNT) begin
                count_nxt_s = count_r;
            end else begin
                count_nxt_s = count_r + CW'(1);
            end
        end else if (ras_pop_valid_in && not_empty_s) begin
            index_nxt_s = index_dec_s;
            count_nxt_s = count_r - CW'(1);
        end else begin
            index_nxt_s = index_r;
            count_nxt_s = count_r;
        end
    end

    // State registers; reset clears the whole stack and wins over any request.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            index_r <= {RAS_INDEX_WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                entries_r[i] <= {RAS_TARGET_WIDTH{1'b0}};
            end
        end else begin
            index_r <= index_nxt_s;
            count_r <= count_nxt_s;
            if (wr_en_s) begin
                entries_r[wr_addr_s] <= ras_push_target_in;
            end
        end
    end

    assign ras_ret_target_out = entries_r[index_r];
    assign ras_empty_out      = ~not_empty_s;
    assign ras_index_out      = index_r;
    assign ras_count_out      = count_r;

endmodule
